fetch_unit: RTL

Instruction fetch stage at the front of the RV32IM pipeline. It drives the decode stage's `instr_i` / `prev_valid_i` inputs and honours decode's `self_ready_o` backpressure. It issues word reads to instruction memory over a request/grant/response-valid bus and buffers returned words in a small in-order FIFO. It also flushes and restarts on redirects from execute or the trap logic.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit - RV32 instruction fetch: credit-limited word requests, in-order response buffer, redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN reports bit-1-misaligned redirect targets as fetch faults. Rev 1.0
module fetch_unit #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        next_ready_i,
   output logic        self_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        fetch_err_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_err_i
);
   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam int             CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_ERR_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [31:0]       r_fpc;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_discard;

   logic [31:0]       r_pcq [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_pcq_rd;
   logic [PTR_W-1:0]  r_pcq_wr;

   logic [31:0]       r_buf_instr [FIFO_DEPTH];
   logic [31:0]       r_buf_pc    [FIFO_DEPTH];
   logic              r_buf_err   [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_buf_rd;
   logic [PTR_W-1:0]  r_buf_wr;
   logic [CNT_W-1:0]  r_buf_cnt;

   logic [CNT_W:0]    w_credit_used;
   logic              w_req;
   logic              w_grant;
   logic              w_rsp;
   logic              w_drop;
   logic              w_push_rsp;
   logic              w_pop;
   logic              w_misalign;
   logic [31:0]       w_redirect_pc_al;
   logic [31:0]       w_push_data;
   logic [CNT_W-1:0]  w_out_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // The slot being popped this cycle counts as free, so a depth-2 buffer sustains one word per cycle.
   assign w_pop         = (r_buf_cnt != '0) && next_ready_i;
   assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_buf_cnt} - (CNT_W + 1)'(w_pop);
   assign w_req         = (r_state == ST_RUN) && (w_credit_used < DEPTH_W);
   assign w_grant       = w_req && imem_gnt_i;

   // A response with nothing outstanding (e.g. one arriving after reset) is ignored entirely.
   assign w_rsp         = imem_rvalid_i && (r_outstanding != '0);
   assign w_drop        = w_rsp && ((r_discard != '0) || redirect_i);
   assign w_push_rsp    = w_rsp && !w_drop;
   assign w_push_data   = imem_err_i ? 32'h0 : imem_rdata_i;
   assign w_out_nxt     = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp);

   assign w_redirect_pc_al = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_misalign = redirect_i && redirect_pc_i[1];
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT:     w_state_nxt = ST_RUN;
         ST_RUN:      if (w_push_rsp && imem_err_i) w_state_nxt = ST_ERR_HOLD;
         ST_ERR_HOLD: w_state_nxt = ST_ERR_HOLD;
         default:     w_state_nxt = ST_BOOT;
      endcase
      if (redirect_i) begin
         w_state_nxt = w_misalign ? ST_ERR_HOLD : ST_RUN;
      end
   end

   // A response consumed in the redirect cycle itself is already retired, hence w_out_nxt for the discard load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fpc         <= BOOT_ADDR & 32'hFFFF_FFFC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_nxt;
         if (redirect_i) begin
            r_fpc     <= w_redirect_pc_al;
            r_discard <= w_out_nxt;
         end else begin
            if (w_grant) begin
               r_fpc <= r_fpc + 32'd4;
            end
            if (w_rsp && (r_discard != '0)) begin
               r_discard <= r_discard - CNT_W'(1);
            end
         end
      end
   end

   // Addresses of live requests only; stale ones are covered by the discard count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcq_rd <= '0;
         r_pcq_wr <= '0;
      end else if (redirect_i) begin
         r_pcq_rd <= '0;
         r_pcq_wr <= '0;
      end else begin
         if (w_grant) begin
            r_pcq_wr <= ptr_inc(r_pcq_wr);
         end
         if (w_push_rsp) begin
            r_pcq_rd <= ptr_inc(r_pcq_rd);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_grant && !redirect_i) begin
         r_pcq[r_pcq_wr] <= r_fpc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_rd  <= '0;
         r_buf_wr  <= '0;
         r_buf_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_buf_instr[i] <= 32'h0;
            r_buf_pc[i]    <= 32'h0;
            r_buf_err[i]   <= 1'b0;
         end
      end else if (redirect_i) begin
         r_buf_rd <= '0;
         if (w_misalign) begin
            r_buf_instr[0] <= 32'h0;
            r_buf_pc[0]    <= redirect_pc_i;
            r_buf_err[0]   <= 1'b1;
            r_buf_wr       <= PTR_W'(1);
            r_buf_cnt      <= CNT_W'(1);
         end else begin
            r_buf_wr  <= '0;
            r_buf_cnt <= '0;
         end
      end else begin
         if (w_push_rsp) begin
            r_buf_instr[r_buf_wr] <= w_push_data;
            r_buf_pc[r_buf_wr]    <= r_pcq[r_pcq_rd];
            r_buf_err[r_buf_wr]   <= imem_err_i;
            r_buf_wr              <= ptr_inc(r_buf_wr);
         end
         if (w_pop) begin
            r_buf_rd <= ptr_inc(r_buf_rd);
         end
         r_buf_cnt <= r_buf_cnt + CNT_W'(w_push_rsp) - CNT_W'(w_pop);
      end
   end

   assign imem_req_o   = w_req;
   assign imem_addr_o  = r_fpc;
   assign self_valid_o = (r_buf_cnt != '0);
   assign instr_o      = r_buf_instr[r_buf_rd];
   assign pc_o         = r_buf_pc[r_buf_rd];
   assign fetch_err_o  = r_buf_err[r_buf_rd];

endmodule
`default_nettype wire
